// File: rtl/nn_pkg.sv
// Shared definitions for the network output-stage blocks: scan state
// encoding, default vector geometry and an index-width helper.
package nn_pkg;

  // Two-state serial scan controller
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_t;

  // Default geometry of the final layer (10 neurons, 16-bit fixed point)
  localparam int DEF_NUM_INPUTS = 10;
  localparam int DEF_DATAWIDTH  = 16;

  // Bits needed to hold an index in 0..n-1 (never narrower than one bit)
  function automatic int index_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/max_finder.sv
// Output classification stage: captures the neuron output vector, scans it
// one element per cycle with a signed compare and reports the arg-max
// (predicted digit) and its value with a single-cycle valid pulse.
module max_finder
  import nn_pkg::*;
#(
  parameter int NUM_INPUTS = DEF_NUM_INPUTS,
  parameter int DATAWIDTH  = DEF_DATAWIDTH,
  parameter int INDEXWIDTH = index_width(NUM_INPUTS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATAWIDTH*NUM_INPUTS-1:0] i_data,
  input  logic [NUM_INPUTS-1:0]           i_valid,
  output logic [INDEXWIDTH-1:0]           o_index,
  output logic [DATAWIDTH-1:0]            o_max,
  output logic                            o_valid,
  output logic                            o_busy
);

  localparam logic [INDEXWIDTH-1:0] LAST_IDX = INDEXWIDTH'(NUM_INPUTS - 1);

  scan_state_t state;
  scan_state_t next_state;

  logic signed [DATAWIDTH-1:0] data_buf [NUM_INPUTS];
  logic        [INDEXWIDTH-1:0] cnt;
  logic signed [DATAWIDTH-1:0] run_max;
  logic        [INDEXWIDTH-1:0] run_idx;

  logic                        capture;
  logic                        scan_step;
  logic                        finish;
  logic signed [DATAWIDTH-1:0] cur_elem;
  logic signed [DATAWIDTH-1:0] new_max;
  logic        [INDEXWIDTH-1:0] new_idx;

  assign o_busy = (state == ST_SCAN);

  // State register; reset aborts any scan in progress
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= next_state;
  end

  // Next-state and datapath control: accept only complete vectors in IDLE
  always_comb begin
    next_state = state;
    capture    = 1'b0;
    scan_step  = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (&i_valid) begin
          capture    = 1'b1;
          next_state = ST_SCAN;
        end
      end
      ST_SCAN: begin
        scan_step = 1'b1;
        if (cnt == LAST_IDX) begin
          finish     = 1'b1;
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Strict signed compare so ties keep the earlier (lower) index
  always_comb begin
    cur_elem = data_buf[cnt];
    new_max  = run_max;
    new_idx  = run_idx;
    if (cur_elem > run_max) begin
      new_max = cur_elem;
      new_idx = cnt;
    end
  end

  // Capture buffer, running result, scan counter and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_INPUTS; k++) data_buf[k] <= '0;
      cnt     <= '0;
      run_max <= '0;
      run_idx <= '0;
      o_index <= '0;
      o_max   <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= finish;
      if (capture) begin
        for (int k = 0; k < NUM_INPUTS; k++)
          data_buf[k] <= i_data[k*DATAWIDTH +: DATAWIDTH];
        run_max <= i_data[DATAWIDTH-1:0];
        run_idx <= '0;
        cnt     <= INDEXWIDTH'(1);
      end else if (scan_step) begin
        run_max <= new_max;
        run_idx <= new_idx;
        if (finish) begin
          cnt     <= '0;
          o_max   <= new_max;
          o_index <= new_idx;
        end else begin
          cnt <= cnt + INDEXWIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_max_finder.sv
// Self-checking bench for max_finder: directed cases from the block's
// behaviour plus randomized vectors compared against an arg-max model.
module tb_max_finder;

  localparam int N  = 10;
  localparam int DW = 16;
  localparam int IW = 4;
  localparam int LATENCY = N - 1;

  logic              clk;
  logic              rst;
  logic [DW*N-1:0]   i_data;
  logic [N-1:0]      i_valid;
  logic [IW-1:0]     o_index;
  logic [DW-1:0]     o_max;
  logic              o_valid;
  logic              o_busy;

  int checks;
  int errors;

  max_finder #(.NUM_INPUTS(N), .DATAWIDTH(DW), .INDEXWIDTH(IW)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_data  (i_data),
    .i_valid (i_valid),
    .o_index (o_index),
    .o_max   (o_max),
    .o_valid (o_valid),
    .o_busy  (o_busy)
  );

  // Free-running 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: first position holding the largest signed element
  function automatic void ref_argmax(input logic [DW*N-1:0] vec,
                                     output int idx, output int mx);
    logic signed [DW-1:0] e;
    idx = 0;
    e   = vec[DW-1:0];
    mx  = int'(e);
    for (int k = 1; k < N; k++) begin
      e = vec[k*DW +: DW];
      if (int'(e) > mx) begin
        mx  = int'(e);
        idx = k;
      end
    end
  endfunction

  function automatic logic [DW*N-1:0] random_vec(input int mode);
    logic [DW*N-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) begin
      case (mode)
        0:       v[k*DW +: DW] = DW'($urandom);
        1:       v[k*DW +: DW] = DW'($urandom_range(0, 3));
        default: v[k*DW +: DW] = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'h8001;
      endcase
    end
    return v;
  endfunction

  // Present a full-valid vector from just after an edge; returns after the
  // capture edge with valid dropped and the data bus scrambled
  task automatic applyStimulus(input logic [DW*N-1:0] vec);
    i_data  = vec;
    i_valid = '1;
    @(posedge clk);
    #1;
    i_valid = '0;
    i_data  = {5{32'($urandom)}};
  endtask

  // Wait (bounded) for the result pulse and compare it with the model;
  // 'elapsed' is the number of cycles since capture already consumed
  task automatic await_result(input string tag, input logic [DW*N-1:0] vec,
                              input int elapsed);
    int exp_idx;
    int exp_mx;
    int cycles;
    ref_argmax(vec, exp_idx, exp_mx);
    cycles = elapsed;
    while (!o_valid && cycles < LATENCY + 6) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    checkOutput({tag, "_latency"}, 32'(cycles), 32'(LATENCY));
    checkOutput({tag, "_index"}, 32'(o_index), 32'(exp_idx));
    checkOutput({tag, "_max"}, 32'(o_max), 32'(exp_mx[DW-1:0]));
    checkOutput({tag, "_busy_done"}, 32'(o_busy), 32'd0);
  endtask

  // Pulse must last exactly one cycle and the result must hold afterwards
  task automatic check_pulse_end(input string tag, input logic [DW*N-1:0] vec);
    int exp_idx;
    int exp_mx;
    ref_argmax(vec, exp_idx, exp_mx);
    @(posedge clk);
    #1;
    checkOutput({tag, "_pulse_drop"}, 32'(o_valid), 32'd0);
    checkOutput({tag, "_hold_index"}, 32'(o_index), 32'(exp_idx));
  endtask

  logic [DW*N-1:0] vec_a;
  logic [DW*N-1:0] vec_b;
  logic [DW*N-1:0] vec_c;
  logic            seen_valid;

  // Directed scenarios followed by randomized vectors
  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b0;
    i_valid = '0;
    i_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_index", 32'(o_index), 32'd0);
    checkOutput("reset_max", 32'(o_max), 32'd0);
    checkOutput("reset_valid", 32'(o_valid), 32'd0);
    checkOutput("reset_busy", 32'(o_busy), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Ascending 1..10
    for (int k = 0; k < N; k++) vec_a[k*DW +: DW] = DW'(k + 1);
    applyStimulus(vec_a);
    checkOutput("asc_busy", 32'(o_busy), 32'd1);
    await_result("asc", vec_a, 0);
    checkOutput("asc_index_const", 32'(o_index), 32'd9);
    check_pulse_end("asc", vec_a);

    // Single positive among negatives
    for (int k = 0; k < N; k++) vec_a[k*DW +: DW] = (k == 3) ? 16'h0700 : 16'hFC00;
    applyStimulus(vec_a);
    await_result("neg", vec_a, 0);
    checkOutput("neg_index_const", 32'(o_index), 32'd3);

    // Ties: all equal, then two equal maxima
    for (int k = 0; k < N; k++) vec_a[k*DW +: DW] = 16'hFFFF;
    applyStimulus(vec_a);
    await_result("tie_all", vec_a, 0);
    checkOutput("tie_all_index_const", 32'(o_index), 32'd0);
    for (int k = 0; k < N; k++) vec_a[k*DW +: DW] = (k == 2 || k == 7) ? 16'h0400 : 16'h0000;
    applyStimulus(vec_a);
    await_result("tie_two", vec_a, 0);
    checkOutput("tie_two_index_const", 32'(o_index), 32'd2);

    // Partial valid must never start a scan
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) vec_a[k*DW +: DW] = DW'(100 - k);
    i_data  = vec_a;
    i_valid = 10'h1FF;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checkOutput("partial_busy", 32'(o_busy), 32'd0);
    end
    applyStimulus(vec_a);
    await_result("partial", vec_a, 0);

    // Mid-scan vector ignored, then back-to-back vector in the pulse cycle
    for (int k = 0; k < N; k++) vec_a[k*DW +: DW] = (k == 5) ? 16'h1234 : DW'(k);
    for (int k = 0; k < N; k++) vec_c[k*DW +: DW] = (k == 0) ? 16'h7FFF : 16'h0000;
    for (int k = 0; k < N; k++) vec_b[k*DW +: DW] = (k == 1) ? 16'h0055 : 16'hF000;
    applyStimulus(vec_a);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    i_data  = vec_c;
    i_valid = '1;
    @(posedge clk);
    #1;
    i_valid = '0;
    await_result("midscan", vec_a, 3);
    checkOutput("midscan_index_const", 32'(o_index), 32'd5);
    applyStimulus(vec_b);
    checkOutput("b2b_busy", 32'(o_busy), 32'd1);
    await_result("b2b", vec_b, 0);
    checkOutput("b2b_index_const", 32'(o_index), 32'd1);

    // Reset in the middle of a scan
    for (int k = 0; k < N; k++) vec_a[k*DW +: DW] = (k == 4) ? 16'h0FFF : 16'h0001;
    applyStimulus(vec_a);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    #1;
    checkOutput("abort_index", 32'(o_index), 32'd0);
    checkOutput("abort_max", 32'(o_max), 32'd0);
    checkOutput("abort_busy", 32'(o_busy), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    seen_valid = 1'b0;
    for (int c = 0; c < N + 2; c++) begin
      @(posedge clk);
      #1;
      if (o_valid) seen_valid = 1'b1;
    end
    checkOutput("abort_no_valid", 32'(seen_valid), 32'd0);
    for (int k = 0; k < N; k++) vec_a[k*DW +: DW] = (k == 8) ? 16'h0200 : 16'hFF00;
    applyStimulus(vec_a);
    await_result("after_reset", vec_a, 0);
    checkOutput("after_reset_index_const", 32'(o_index), 32'd8);

    // Randomized vectors: full range, small range (ties), most-negative values
    for (int t = 0; t < 30; t++) begin
      vec_a = random_vec(t % 3);
      applyStimulus(vec_a);
      await_result("rand", vec_a, 0);
      if (t % 4 == 0) check_pulse_end("rand", vec_a);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
